// File: rtl/seq_chunk_adder.sv
// ============================================================================
// seq_chunk_adder: multi-cycle add/subtract, CHUNK bits per clock, LSB first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             carry;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout, msb_cin, last_chunk;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign last_chunk = (k == KW'(NCH - 1));

  assign a_chunk = a_q[int'(k)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(k)*CHUNK +: CHUNK];
  assign {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                 + {{CHUNK{1'b0}}, carry};
  // Carry into the chunk MSB recovered from the sum bit: s = a ^ b ^ c_in.
  assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  always_comb begin
    res_next = res_q;
    res_next[int'(k)*CHUNK +: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + ~cin, so cout reads as "no borrow".
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            k     <= '0;
          end
        end
        RUN: begin
          res_q <= res_next;
          carry <= chunk_cout;
          k     <= k + KW'(1);
          if (last_chunk) begin
            sum  <= res_next;
            cout <= chunk_cout;
            ovf  <= chunk_cout ^ msb_cin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// ============================================================================
// tb_seq_chunk_adder: random and directed checks of three chunk sizes in lockstep.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_chunk_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;

  logic         in_ready_o  [3];
  logic         out_valid_o [3];
  logic [W-1:0] sum_o       [3];
  logic         cout_o      [3];
  logic         ovf_o       [3];
  logic         busy_o      [3];

  int nch [3] = '{16, 4, 1};
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_o[0]),
    .out_ready(out_ready), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]),
    .busy(busy_o[0]));

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_o[1]),
    .out_ready(out_ready), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]),
    .busy(busy_o[1]));

  seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) dut_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_o[2]),
    .out_ready(out_ready), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]),
    .busy(busy_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [17:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                        input logic c, input logic s);
    int ua, ub, sa, sb, r, sr, ci;
    logic co, ov;
    ua = int'(xa);
    ub = int'(xb);
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    ci = c ? 1 : 0;
    if (!s) begin
      r  = ua + ub + ci;
      co = (r > 65535);
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      co = (ua >= ub + ci);
      sr = sa - sb - ci;
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, r[15:0]};
  endfunction

  task automatic drive_ops(input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic c, input logic s);
    a = xa; b = xb; cin = c; sub = s;
  endtask

  // Issue one handshake at the next edge, then release in_valid.
  task automatic start(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic c, input logic s);
    @(negedge clk);
    drive_ops(xa, xb, c, s);
    for (int i = 0; i < 3; i++) check($sformatf("in_ready_pre[%0d]", i), 32'(in_ready_o[i]), 1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Handshake edge has just passed; count edges until each out_valid rises.
  task automatic wait_check(input logic [17:0] exp);
    int lat [3];
    bit all_seen;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    all_seen = 1'b0;
    for (int n = 1; n <= 40 && !all_seen; n++) begin
      @(posedge clk);
      #1;
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid_o[i] && lat[i] < 0) lat[i] = n;
        if (lat[i] < 0) all_seen = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(nch[i]));
      check($sformatf("sum[%0d]", i),  32'(sum_o[i]),  32'(exp[15:0]));
      check($sformatf("cout[%0d]", i), 32'(cout_o[i]), 32'(exp[16]));
      check($sformatf("ovf[%0d]", i),  32'(ovf_o[i]),  32'(exp[17]));
      check($sformatf("busy_done[%0d]", i), 32'(busy_o[i]), 1);
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("in_ready_post[%0d]", i), 32'(in_ready_o[i]), 1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) check($sformatf("out_valid_post[%0d]", i), 32'(out_valid_o[i]), 0);
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                    input logic c, input logic s);
    start(xa, xb, c, s);
    // in_valid was dropped a half-cycle after the handshake; resync to that edge.
    wait_check_from_half(model(xa, xb, c, s));
    retire();
  endtask

  // Same as wait_check but entered at the negedge following the handshake.
  task automatic wait_check_from_half(input logic [17:0] exp);
    wait_check(exp);
  endtask

  initial begin
    logic [17:0] exp_x, exp_y;
    logic [W-1:0] ra, rb;

    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), 32'(out_valid_o[i]), 0);
      check($sformatf("rst_sum[%0d]", i), 32'(sum_o[i]), 0);
      check($sformatf("rst_busy[%0d]", i), 32'(busy_o[i]), 0);
      check($sformatf("rst_in_ready[%0d]", i), 32'(in_ready_o[i]), 1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(16'h1234, 16'h0FF0, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op(16'h0005, 16'h0007, 1'b0, 1'b1);
    op(16'h8000, 16'h0001, 1'b0, 1'b1);
    op(16'h0007, 16'h0007, 1'b1, 1'b1);

    // Back-pressure in DONE while new operands wait on in_valid.
    exp_x = model(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    exp_y = model(16'h0F0F, 16'h3000, 1'b0, 1'b1);
    start(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    wait_check(exp_x);
    @(negedge clk);
    drive_ops(16'h0F0F, 16'h3000, 1'b0, 1'b1);
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_in_ready[%0d]", i), 32'(in_ready_o[i]), 0);
        check($sformatf("hold_out_valid[%0d]", i), 32'(out_valid_o[i]), 1);
        check($sformatf("hold_sum[%0d]", i), 32'(sum_o[i]), 32'(exp_x[15:0]));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_idle[%0d]", i), 32'(in_ready_o[i]), 1);
      check($sformatf("bp_kept_sum[%0d]", i), 32'(sum_o[i]), 32'(exp_x[15:0]));
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_check(exp_y);
    retire();

    // Random sweep; input ports scrambled during RUN must not matter.
    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      exp_x = model(ra, rb, 1'($urandom), 1'($urandom));
      start(ra, rb, exp_x[0] ^ exp_x[0], 1'b0);
      drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_check(model(ra, rb, 1'b0, 1'b0));
      retire();
      start(ra, rb, 1'b1, 1'b1);
      drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_check(model(ra, rb, 1'b1, 1'b1));
      retire();
      cin = 1'($urandom);
      sub = 1'($urandom);
      exp_y = model(ra, rb, cin, sub);
      start(ra, rb, cin, sub);
      wait_check(exp_y);
      retire();
    end

    // Asynchronous reset while the narrow-chunk instances are still in RUN.
    start(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_rst_out_valid[%0d]", i), 32'(out_valid_o[i]), 0);
      check($sformatf("mid_rst_sum[%0d]", i), 32'(sum_o[i]), 0);
      check($sformatf("mid_rst_cout[%0d]", i), 32'(cout_o[i]), 0);
      check($sformatf("mid_rst_ovf[%0d]", i), 32'(ovf_o[i]), 0);
      check($sformatf("mid_rst_busy[%0d]", i), 32'(busy_o[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_in_ready[%0d]", i), 32'(in_ready_o[i]), 1);
      check($sformatf("post_rst_out_valid[%0d]", i), 32'(out_valid_o[i]), 0);
    end
    op(16'h1234, 16'h0FF0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
